// File: rtl/board_uart_tx.sv
// Streams the ultimate tic-tac-toe board to a host as 101 ASCII bytes over 8N1 UART.
// Reads micro-cells and macro results through the board RAM read ports.
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic [3:0] addr_macro,
    output logic [3:0] addr_micro,
    input  logic [1:0] celula,
    output logic [3:0] addr_estado,
    input  logic [1:0] estado,
    output logic       tx,
    output logic       ocupado,
    output logic       pronto
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0] IDX_LAST = 7'd100;

    typedef enum logic [2:0] {
        OCIOSO,
        PREP,
        START,
        DADOS,
        STOP,
        FIM
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [6:0]    idx_q;
    logic [3:0]    row_q;
    logic [3:0]    col_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          ocupado_q;
    logic          pronto_q;
    logic [3:0]    macro_q;
    logic [3:0]    micro_q;
    logic [3:0]    estado_addr_q;

    logic [3:0]    row_d;
    logic [3:0]    col_d;
    logic [7:0]    byte_d;

    function automatic logic [7:0] to_ascii(input logic [1:0] v);
        logic [7:0] c;
        case (v)
            2'b00:   c = 8'h2E;
            2'b01:   c = 8'h58;
            2'b10:   c = 8'h4F;
            default: c = 8'h2D;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] div3(input logic [3:0] v);
        logic [3:0] q;
        if (v >= 4'd6) begin
            q = 4'd2;
        end else if (v >= 4'd3) begin
            q = 4'd1;
        end else begin
            q = 4'd0;
        end
        return q;
    endfunction

    function automatic logic [3:0] mod3(input logic [3:0] v);
        return v - (div3(v) * 4'd3);
    endfunction

    // Column 9 of each line is the newline; row 9 is the macro-result line.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (idx_q != 7'd0) begin
            if (col_q == 4'd9) begin
                row_d = row_q + 4'd1;
                col_d = 4'd0;
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    always_comb begin
        byte_d = to_ascii(celula);
        if (idx_q == 7'd0) begin
            byte_d = 8'h23;
        end else if (col_q == 4'd9) begin
            byte_d = 8'h0A;
        end else if (row_q == 4'd9) begin
            byte_d = to_ascii(estado);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= OCIOSO;
            cnt_q         <= '0;
            bit_q         <= 3'd0;
            idx_q         <= 7'd0;
            row_q         <= 4'd0;
            col_q         <= 4'd0;
            shift_q       <= 8'h00;
            tx_q          <= 1'b1;
            ocupado_q     <= 1'b0;
            pronto_q      <= 1'b0;
            macro_q       <= 4'd0;
            micro_q       <= 4'd0;
            estado_addr_q <= 4'd0;
        end else begin
            unique case (state_q)
                OCIOSO: begin
                    tx_q <= 1'b1;
                    if (iniciar) begin
                        state_q   <= PREP;
                        idx_q     <= 7'd0;
                        row_q     <= 4'd0;
                        col_q     <= 4'd0;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b1;
                    end
                end
                PREP: begin
                    if (cnt_q == '0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        shift_q <= byte_d;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= DADOS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DADOS: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            pronto_q <= 1'b1;
                            state_q  <= FIM;
                        end else begin
                            idx_q   <= idx_q + 7'd1;
                            row_q   <= row_d;
                            col_q   <= col_d;
                            state_q <= PREP;
                            // Addresses move only for RAM-backed bytes.
                            if (col_d != 4'd9) begin
                                if (row_d == 4'd9) begin
                                    estado_addr_q <= col_d;
                                end else begin
                                    macro_q <= div3(row_d) * 4'd3 + div3(col_d);
                                    micro_q <= mod3(row_d) * 4'd3 + mod3(col_d);
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIM: begin
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    state_q   <= OCIOSO;
                end
                default: begin
                    state_q <= OCIOSO;
                end
            endcase
        end
    end

    assign addr_macro  = macro_q;
    assign addr_micro  = micro_q;
    assign addr_estado = estado_addr_q;
    assign tx          = tx_q;
    assign ocupado     = ocupado_q;
    assign pronto      = pronto_q;

endmodule

// File: tb/tb_board_uart_tx.sv
// Bench for board_uart_tx: decodes the UART line and checks frames against a board model.
module tb_board_uart_tx;

    localparam int CPB       = 4;
    localparam int BYTE_CYC  = 2 + 10 * CPB;
    localparam int FRAME_CYC = 101 * BYTE_CYC;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] addr_macro;
    logic [3:0] addr_micro;
    logic [1:0] celula;
    logic [3:0] addr_estado;
    logic [1:0] estado;
    logic       tx;
    logic       ocupado;
    logic       pronto;

    logic [1:0] board [9][9];
    logic [1:0] est [9];

    byte unsigned  rx_q [$];
    byte unsigned  exp_q [$];
    int            st_cyc [$];
    logic [11:0]   st_addr [$];
    int            rise_cyc [$];
    int            pr_cyc [$];
    int            ferr;
    int            cyc;
    int            total;
    int            bad;

    board_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .addr_macro (addr_macro),
        .addr_micro (addr_micro),
        .celula     (celula),
        .addr_estado(addr_estado),
        .estado     (estado),
        .tx         (tx),
        .ocupado    (ocupado),
        .pronto     (pronto)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        celula = 2'b00;
        estado = 2'b00;
        if (addr_macro < 4'd9 && addr_micro < 4'd9)
            celula = board[int'(addr_macro)][int'(addr_micro)];
        if (addr_estado < 4'd9)
            estado = est[int'(addr_estado)];
    end

    // UART receiver: sample mid-bit, record start time and addresses.
    initial begin : mon_rx
        logic [7:0] d;
        forever begin
            @(negedge clock);
            if (tx === 1'b0) begin
                st_cyc.push_back(cyc);
                st_addr.push_back({addr_macro, addr_micro, addr_estado});
                repeat (CPB + CPB / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    d[i] = tx;
                    repeat (CPB) @(negedge clock);
                end
                if (tx !== 1'b1) ferr++;
                rx_q.push_back(d);
            end
        end
    end

    initial begin : mon_ctl
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (pronto === 1'b1) pr_cyc.push_back(cyc);
            if (ocupado === 1'b1 && prev !== 1'b1) rise_cyc.push_back(cyc);
            prev = ocupado;
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        st_cyc.delete();
        st_addr.delete();
        rise_cyc.delete();
        pr_cyc.delete();
        ferr = 0;
    endtask

    function automatic byte unsigned chr(input logic [1:0] v);
        byte unsigned c;
        case (v)
            2'b00:   c = 8'h2E;
            2'b01:   c = 8'h58;
            2'b10:   c = 8'h4F;
            default: c = 8'h2D;
        endcase
        return c;
    endfunction

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(8'h23);
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++)
                exp_q.push_back(chr(board[(r / 3) * 3 + c / 3][(r % 3) * 3 + c % 3]));
            exp_q.push_back(8'h0A);
        end
        for (int m = 0; m < 9; m++) exp_q.push_back(chr(est[m]));
        exp_q.push_back(8'h0A);
    endtask

    task automatic fill_empty();
        for (int a = 0; a < 9; a++) begin
            est[a] = 2'b00;
            for (int b = 0; b < 9; b++) board[a][b] = 2'b00;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 9; a++) begin
            est[a] = 2'($urandom_range(3, 0));
            for (int b = 0; b < 9; b++) board[a][b] = 2'($urandom_range(2, 0));
        end
    endtask

    task automatic wait_pronto(input int n, input int budget);
        int b;
        b = 0;
        while (pr_cyc.size() < n && b < budget) begin
            @(negedge clock);
            b++;
        end
        chk("pronto_seen", pr_cyc.size(), n);
    endtask

    task automatic cmp_frame(input string tag, input int off);
        int nmis;
        int first;
        nmis = 0;
        first = -1;
        for (int i = 0; i < 101; i++) begin
            if (off + i >= rx_q.size() || rx_q[off + i] !== exp_q[i]) begin
                nmis++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_bytes_wrong"}, nmis, 0);
        if (nmis != 0) $display("  first bad byte index %0d", first);
    endtask

    task automatic start_pulse();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin : main
        int gaps;
        logic [11:0] a;
        int w;
        total = 0;
        bad = 0;
        cyc = 0;
        ferr = 0;
        reset = 1'b1;
        iniciar = 1'b0;
        fill_empty();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pronto", int'(pronto), 0);
        chk("rst_addr_macro", int'(addr_macro), 0);
        chk("rst_addr_micro", int'(addr_micro), 0);
        chk("rst_addr_estado", int'(addr_estado), 0);

        // Empty board
        clear_mon();
        fill_empty();
        build_exp();
        start_pulse();
        wait_pronto(1, FRAME_CYC + 500);
        repeat (60) @(negedge clock);
        chk("empty_len", rx_q.size(), 101);
        cmp_frame("empty", 0);
        chk("empty_pronto_cnt", pr_cyc.size(), 1);
        chk("empty_frame_cycles", pr_cyc[0] - rise_cyc[0], FRAME_CYC);
        chk("empty_prep_before_start", st_cyc[0] - rise_cyc[0], 2);
        gaps = 0;
        for (int i = 0; i + 1 < st_cyc.size(); i++)
            if (st_cyc[i + 1] - st_cyc[i] != BYTE_CYC) gaps++;
        chk("empty_byte_period", gaps, 0);
        chk("empty_framing", ferr, 0);
        chk("empty_idle_ocupado", int'(ocupado), 0);

        // Single X in the centre cell and centre macro won by X
        clear_mon();
        fill_empty();
        board[4][4] = 2'b01;
        est[4] = 2'b01;
        build_exp();
        start_pulse();
        wait_pronto(1, FRAME_CYC + 500);
        repeat (60) @(negedge clock);
        chk("x_len", rx_q.size(), 101);
        chk("x_row4_col4", int'(rx_q[45]), 'h58);
        chk("x_row4_col0", int'(rx_q[41]), 'h2E);
        chk("x_macro4", int'(rx_q[95]), 'h58);
        cmp_frame("x", 0);

        // Random board, address sequencing, ignored mid-frame start
        clear_mon();
        fill_random();
        build_exp();
        start_pulse();
        repeat (1000) @(negedge clock);
        start_pulse();
        wait_pronto(1, FRAME_CYC + 500);
        repeat (200) @(negedge clock);
        chk("rnd_len", rx_q.size(), 101);
        cmp_frame("rnd", 0);
        chk("rnd_pronto_cnt", pr_cyc.size(), 1);
        chk("rnd_frame_cnt", rise_cyc.size(), 1);
        chk("rnd_framing", ferr, 0);
        for (int c = 0; c < 9; c++) begin
            a = (31 + c < st_addr.size()) ? st_addr[31 + c] : 12'hFFF;
            chk("row3_addr_macro", int'(a[11:8]), 3 + c / 3);
            chk("row3_addr_micro", int'(a[7:4]), c % 3);
        end
        a = (99 < st_addr.size()) ? st_addr[99] : 12'hFFF;
        chk("macro8_addr_estado", int'(a[3:0]), 8);

        // Reset during data bits of byte 50, then a clean frame
        clear_mon();
        fill_random();
        build_exp();
        start_pulse();
        w = 0;
        while (st_cyc.size() < 51 && w < FRAME_CYC) begin
            @(negedge clock);
            w++;
        end
        chk("byte50_reached", int'(st_cyc.size() >= 51), 1);
        repeat (CPB + 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_tx", int'(tx), 1);
        chk("abort_ocupado", int'(ocupado), 0);
        chk("abort_pronto", int'(pronto), 0);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        chk("abort_no_pronto", pr_cyc.size(), 0);
        clear_mon();
        fill_random();
        build_exp();
        start_pulse();
        wait_pronto(1, FRAME_CYC + 500);
        repeat (60) @(negedge clock);
        chk("after_abort_len", rx_q.size(), 101);
        cmp_frame("after_abort", 0);

        // iniciar held high: back-to-back frames
        clear_mon();
        fill_random();
        build_exp();
        @(negedge clock);
        iniciar = 1'b1;
        wait_pronto(2, 2 * FRAME_CYC + 500);
        iniciar = 1'b0;
        repeat (100) @(negedge clock);
        chk("b2b_frames", rise_cyc.size(), 2);
        chk("b2b_pronto_cnt", pr_cyc.size(), 2);
        chk("b2b_len", rx_q.size(), 202);
        cmp_frame("b2b_first", 0);
        cmp_frame("b2b_second", 101);
        chk("b2b_gap", rise_cyc[1] - pr_cyc[0], 2);
        chk("b2b_prep0", st_cyc[0] - rise_cyc[0], 2);
        chk("b2b_prep1", st_cyc[101] - rise_cyc[1], 2);
        chk("b2b_idle_ocupado", int'(ocupado), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
